// File: rtl/add_share_sched_if.sv
// Bundles the requester, shared-adder and response channels of add_share_sched.
interface add_share_sched_if #(
  parameter int N = 4,
  parameter int W = 16
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;

  logic           add_start;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_y;
  logic           add_valid;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           spurious_err;

  // Environment side: requesters, the adder itself and the response consumer.
  modport master (
    output req_valid, req_a, req_b, add_y, add_valid, rsp_ready,
    input  req_ready, add_start, add_a, add_b,
           rsp_valid, rsp_id, rsp_data, rsp_err, spurious_err
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, add_y, add_valid, rsp_ready,
    output req_ready, add_start, add_a, add_b,
           rsp_valid, rsp_id, rsp_data, rsp_err, spurious_err
  );
endinterface

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one registered adder among N requesters.
// One operation is in flight at a time: IDLE grants, ISSUE pulses start,
// WAIT collects the result (or times out), RESP holds the tagged answer.
module add_share_sched #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  add_share_sched_if.slave  bus
);
  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   add_a_q, add_a_d;
  logic [W-1:0]   add_b_q, add_b_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           spur_q, spur_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   op_a [N];
  logic [W-1:0]   op_b [N];
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  int             scan_idx;
  logic           req_hs;

  // Accepting is only possible in IDLE and never while reset is held.
  assign req_hs = rst_n && (state_q == IDLE) && grant_found;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign op_a[gi]          = bus.req_a[gi*W +: W];
      assign op_b[gi]          = bus.req_b[gi*W +: W];
      assign bus.req_ready[gi] = req_hs && (grant_idx == IDW'(gi));
    end
  endgenerate

  // Pick the first asserted request at or after rr_ptr, wrapping; scanning
  // downward lets the closest candidate overwrite farther ones.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (bus.req_valid[IDW'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan_idx);
      end
    end
  end

  // Next-state and datapath updates for the four-phase operation.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    // A result strobe is only legitimate while waiting for one.
    spur_d     = spur_q | (bus.add_valid && (state_q != WAIT));
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          add_a_d  = op_a[grant_idx];
          add_b_d  = op_b[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the last allowed cycle still counts as good.
        if (bus.add_valid) begin
          rsp_data_d = bus.add_y;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      spur_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      spur_q     <= spur_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.add_start    = (state_q == ISSUE);
  assign bus.add_a        = add_a_q;
  assign bus.add_b        = add_b_q;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.spurious_err = spur_q;
endmodule

// File: doc/add_share_sched.md
# add_share_sched

Round-robin scheduler that shares one registered adder datapath among N requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester at a time and drives the adder's start/a/b inputs. It waits for the adder's one-cycle valid, then returns the sum tagged with the requester id on a response channel. It also polices the adder's valid protocol: a missing valid raises a timeout, and an unexpected valid raises a spurious-valid error.

## Interface
- N, 4, number of requesters (2..16)
- W, 16, operand/result width
- TIMEOUT, 8, cycles to wait in WAIT for add_valid before declaring an error (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept, one-hot or zero
- req_a  in  N*W  operand A, requester i at bits [i*W +: W]
- req_b  in  N*W  operand B, same packing
- add_start  out  1  one-cycle start pulse to the shared adder
- add_a, add_b  out  W  operands to the adder, registered
- add_y  in  W  adder result
- add_valid  in  1  adder result valid, one cycle after add_start
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(N)  index of the requester being answered
- rsp_data  out  W  sum (a+b mod 2^W), or 0 on error
- rsp_err  out  1  response terminated by timeout
- spurious_err  out  1  sticky: add_valid seen outside WAIT

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - Grant goes to the first asserted req_valid, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1, combinationally, only in IDLE; req_ready is forced to 0 while rst_n=0.
  - On handshake: latch a/b into add_a/add_b, latch id, set rr_ptr=(grant+1) mod N, go to ISSUE.
- **ISSUE**: add_start=1 for exactly this cycle; go to WAIT and clear the timeout counter.
- **WAIT**
  - If add_valid=1: capture add_y into rsp_data, set rsp_err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set rsp_data=0 and rsp_err=1, then go to RESP.
- **RESP**
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On handshake, go to IDLE.
- **spurious_err**: set when add_valid=1 in IDLE, ISSUE or RESP. It stays set until reset.
- **Arithmetic**: no carry-out. Sum wrap-around is the adder's responsibility; the scheduler passes add_y through unchanged.
- **rr_ptr**: reset 0. It is updated only on a request handshake.
- **Reset mid-operation**: all state is cleared asynchronously and the in-flight operation is dropped with no response.
- **Reset values**: add_start=0, add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, spurious_err=0, req_ready=0.

## Timing
- Request handshake at cycle T.
- add_start=1 at T+1, with add_a/add_b already valid at T+1.
- add_valid is expected at T+2; rsp_valid=1 at T+3.
- With rsp_ready tied high, the scheduler returns to IDLE at T+4. Peak throughput is one operation per 4 cycles.
- A request held through RESP is granted in the first IDLE cycle.
- Timeout: if no add_valid arrives, rsp_valid rises TIMEOUT+1 cycles after ISSUE.
- add_valid arriving in the same cycle as the timeout is treated as a normal result (valid wins).
- req_valid is not required to stay asserted before grant; only the handshake cycle's operands are used.

## Test plan
- Single request, requester 2, a=0x0123, b=0x0456 -> add_start at T+1; rsp_valid at T+3 with rsp_id=2, rsp_data=0x0579, rsp_err=0.
- All 4 req_valid held high with distinct operands, rsp_ready=1 -> responses in id order 0,1,2,3,0, each 4 cycles apart with correct sums.
- Wrap: a=0xFFFF, b=0x0001 -> rsp_data=0x0000, rsp_err=0.
- rsp_ready held low for 5 cycles during RESP -> rsp_valid/rsp_id/rsp_data remain stable; req_ready stays 0 for all requesters; the next grant comes only after the handshake.
- Adder model suppresses add_valid -> rsp_valid rises 9 cycles after add_start with rsp_err=1, rsp_data=0. Separately, an injected add_valid in IDLE -> spurious_err=1 until rst_n is asserted.
- rst_n asserted during WAIT -> all outputs go to reset values immediately; no response appears after release; the next request is serviced from rr_ptr=0.
